reg_file: RTL and testbench



---
 rtl/reg_file.sv | 84 ++++++++
 tb/tb_reg_file.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: B..Z byte registers plus PC/SP with byte/pair access and in-place INC/DCR/INC2.
// Optional DE<->HL swap is built only when REG_FILE_XCHG_EN is defined.
module reg_file #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [15:0] SP_RESET = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_in,
  input  logic        write_en,
  input  logic [4:0]  write_sel,
  input  logic [4:0]  read_sel,
  input  logic        out_en,
  input  logic [1:0]  ext,
  input  logic        xchg,
  output logic [15:0] out
);
  logic [7:0][7:0]  r_q, r_d;
  logic [15:0]      pc_q, pc_d, sp_q, sp_d;
  logic [7:0][15:0] pr;
  logic [7:0]       rb;
  logic [2:0]       pi;
  logic [15:0]      delta, pv;
  logic             xa;
`ifdef REG_FILE_XCHG_EN
  assign xa = xchg;
`else
  logic unused_xchg;
  assign xa = 1'b0;
  assign unused_xchg = xchg;
`endif
  // r_q index 0..7 = B,C,D,E,H,L,W,Z; pair n is {r_q[2n], r_q[2n+1]}
  always_comb begin
    pr = '0;
    pr[0] = {r_q[0], r_q[1]};
    pr[1] = {r_q[2], r_q[3]};
    pr[2] = {r_q[4], r_q[5]};
    pr[3] = {r_q[6], r_q[7]};
    pr[4] = pc_q;
    pr[5] = sp_q;
  end
  assign rb = read_sel[3] ? (read_sel[2] ? 8'h00 :
              read_sel[1] ? (read_sel[0] ? sp_q[7:0] : sp_q[15:8]) :
                            (read_sel[0] ? pc_q[7:0] : pc_q[15:8])) : r_q[read_sel[2:0]];
  assign out = !out_en ? 16'h0000 : read_sel[4] ? pr[read_sel[3:1]] : {8'h00, rb};
  assign pi = write_sel[3:1];
  assign delta = ext == 2'd1 ? 16'd1 : ext == 2'd2 ? 16'hFFFF : 16'd2;
  assign pv = write_en ? bus_in : pr[pi] + delta;
  always_comb begin
    r_d = r_q;
    pc_d = pc_q;
    sp_d = sp_q;
    if (xa) begin
      r_d[2] = r_q[4];
      r_d[3] = r_q[5];
      r_d[4] = r_q[2];
      r_d[5] = r_q[3];
    end
    // a write overlays the swap; ext only runs when neither write nor swap is active
    if (write_en ? write_sel[4] : (ext != 2'b00 && !xa)) begin
      if (!pi[2]) {r_d[{pi[1:0], 1'b0}], r_d[{pi[1:0], 1'b1}]} = pv;
      else if (pi == 3'd4) pc_d = pv;
      else if (pi == 3'd5) sp_d = pv;
    end
    if (write_en && !write_sel[4]) begin
      if (!write_sel[3]) r_d[write_sel[2:0]] = bus_in[7:0];
      else if (write_sel[3:0] == 4'd8) pc_d[15:8] = bus_in[7:0];
      else if (write_sel[3:0] == 4'd9) pc_d[7:0] = bus_in[7:0];
      else if (write_sel[3:0] == 4'd10) sp_d[15:8] = bus_in[7:0];
      else if (write_sel[3:0] == 4'd11) sp_d[7:0] = bus_in[7:0];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
      pc_q <= PC_RESET;
      sp_q <= SP_RESET;
    end else begin
      r_q <= r_d;
      pc_q <= pc_d;
      sp_q <= sp_d;
    end
  end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed stimulus for reg_file, checked against a register-array model every cycle.
`timescale 1ns/1ps
module tb_reg_file;
  localparam logic [15:0] PCR = 16'h0100;
  localparam logic [15:0] SPR = 16'hFFFF;
  logic        clk = 0, rst = 0;
  logic [15:0] bus_in = 0;
  logic        write_en = 0, out_en = 0, xchg = 0;
  logic [4:0]  write_sel = 0, read_sel = 0;
  logic [1:0]  ext = 0;
  logic [15:0] out;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  reg_file #(.PC_RESET(PCR), .SP_RESET(SPR)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .write_en(write_en), .write_sel(write_sel),
    .read_sel(read_sel), .out_en(out_en), .ext(ext), .xchg(xchg), .out(out)
  );
  logic [7:0]  m_r [8];
  logic [15:0] m_pc, m_sp;
  logic [7:0]  n_r [8];
  logic [15:0] n_pc, n_sp;
  function automatic logic [15:0] m_pair(input int i);
    if (i < 4) return {m_r[2*i], m_r[2*i+1]};
    if (i == 4) return m_pc;
    if (i == 5) return m_sp;
    return 16'h0000;
  endfunction
  function automatic logic [15:0] m_read(input logic [4:0] s, input logic en);
    if (!en) return 16'h0000;
    if (s[4]) return m_pair(int'(s[3:1]));
    case (s[3:0])
      4'd8:    return {8'h00, m_pc[15:8]};
      4'd9:    return {8'h00, m_pc[7:0]};
      4'd10:   return {8'h00, m_sp[15:8]};
      4'd11:   return {8'h00, m_sp[7:0]};
      4'd12, 4'd13, 4'd14, 4'd15: return 16'h0000;
      default: return {8'h00, m_r[s[2:0]]};
    endcase
  endfunction
  task automatic n_set_pair(input int i, input logic [15:0] v);
    if (i < 4) begin
      n_r[2*i] = v[15:8];
      n_r[2*i+1] = v[7:0];
    end else if (i == 4) n_pc = v;
    else if (i == 5) n_sp = v;
  endtask
  task automatic n_swap();
    n_r[2] = m_r[4]; n_r[3] = m_r[5]; n_r[4] = m_r[2]; n_r[5] = m_r[3];
  endtask
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_r[i] <= 8'h00;
      m_pc <= PCR;
      m_sp <= SPR;
    end else begin
      n_r = m_r; n_pc = m_pc; n_sp = m_sp;
      if (write_en) begin
`ifdef REG_FILE_XCHG_EN
        if (xchg) n_swap();
`endif
        if (write_sel[4]) n_set_pair(int'(write_sel[3:1]), bus_in);
        else if (write_sel[3:0] < 4'd8) n_r[write_sel[2:0]] = bus_in[7:0];
        else if (write_sel[3:0] == 4'd8) n_pc[15:8] = bus_in[7:0];
        else if (write_sel[3:0] == 4'd9) n_pc[7:0] = bus_in[7:0];
        else if (write_sel[3:0] == 4'd10) n_sp[15:8] = bus_in[7:0];
        else if (write_sel[3:0] == 4'd11) n_sp[7:0] = bus_in[7:0];
      end
`ifdef REG_FILE_XCHG_EN
      else if (xchg) n_swap();
`endif
      else if (ext != 2'd0)
        n_set_pair(int'(write_sel[3:1]), m_pair(int'(write_sel[3:1])) +
                   (ext == 2'd1 ? 16'd1 : ext == 2'd2 ? 16'hFFFF : 16'd2));
      m_r <= n_r; m_pc <= n_pc; m_sp <= n_sp;
    end
  end
  always @(negedge clk) begin
    tests++;
    if (out !== m_read(read_sel, out_en)) begin
      fails++;
      $display("FAIL cycle_cmp t=%0t sel=%b en=%b out=%h exp=%h", $time, read_sel, out_en, out, m_read(read_sel, out_en));
    end
  end
  task automatic chk(input string n, input logic [15:0] e);
    #1;
    tests++;
    if (out !== e) begin
      fails++;
      $display("FAIL %s out=%h exp=%h", n, out, e);
    end
  endtask
  task automatic sweep();
    logic [4:0] keep;
    keep = read_sel;
    for (int s = 0; s < 32; s++) begin
      read_sel = 5'(s);
      #0.1;
      tests++;
      if (out !== m_read(read_sel, 1'b1)) begin
        fails++;
        $display("FAIL sweep sel=%0d out=%h exp=%h", s, out, m_read(read_sel, 1'b1));
      end
    end
    read_sel = keep;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic we, input logic [4:0] ws, input logic [15:0] bi, input logic [1:0] e, input logic x);
    write_en = we; write_sel = ws; bus_in = bi; ext = e; xchg = x;
    tick();
    write_en = 0; ext = 0; xchg = 0;
  endtask
  initial begin
    #1 rst = 1;
    out_en = 1;
    read_sel = 5'b11000; chk("rst_pc", 16'h0100);
    read_sel = 5'b11010; chk("rst_sp", 16'hFFFF);
    for (int i = 0; i < 8; i++) begin
      read_sel = 5'(i);
      chk("rst_byte", 16'h0000);
    end
    @(negedge clk); rst = 0;
    tick();
    op(1, 5'd1, 16'h00FF, 0, 0);
    op(1, 5'd0, 16'h0012, 0, 0);
    op(0, 5'd1, 16'h0000, 1, 0);
    read_sel = 5'b10000; chk("inc_bc_carry", 16'h1300);
    op(0, 5'b10000, 16'h0000, 2, 0); chk("dcr_bc", 16'h12FF);
    read_sel = 5'b11000;
    op(1, 5'b11000, 16'hFFFE, 0, 0);
    op(0, 5'b11000, 16'h0000, 3, 0); chk("pc_inc2_wrap", 16'h0000);
    op(0, 5'b11000, 16'h0000, 3, 0); chk("pc_inc2", 16'h0002);
    read_sel = 5'b11010;
    op(1, 5'b11010, 16'h0000, 0, 0);
    op(0, 5'b11010, 16'h0000, 2, 0); chk("sp_dcr_wrap", 16'hFFFF);
    read_sel = 5'b11000;
    write_en = 1; write_sel = 5'b11000; bus_in = 16'h4000; ext = 1;
    chk("pre_edge_old_pc", 16'h0002);
    tick();
    write_en = 0; ext = 0;
    chk("write_beats_ext", 16'h4000);
    ext = 1; write_sel = 5'b11000;
    tick(); chk("pc_inc", 16'h4001);
    rst = 1; chk("async_rst_pc", 16'h0100);
    ext = 3;
    @(negedge clk); rst = 0;
    tick(); ext = 0;
    chk("post_rst_cmd", 16'h0102);
    read_sel = 5'd8; chk("byte_pch", 16'h0001);
    read_sel = 5'd9; chk("byte_pcl", 16'h0002);
    out_en = 0; chk("out_en_low", 16'h0000);
    out_en = 1;
    read_sel = 5'd12; chk("unused_sel", 16'h0000);
    op(1, 5'd12, 16'hBEEF, 0, 0);
    op(0, 5'b11100, 16'h0000, 1, 0);
    op(1, 5'd10, 16'h0033, 0, 0);
    op(1, 5'd11, 16'h0044, 0, 0);
    op(1, 5'd7, 16'h00FF, 0, 0);
    op(0, 5'd7, 16'h0000, 1, 0);
    op(1, 5'd4, 16'h0055, 2, 0);
    sweep();
    op(1, 5'b10010, 16'h1234, 0, 0);
    op(1, 5'b10100, 16'hABCD, 0, 0);
    op(0, 5'd0, 16'h0000, 0, 1);
`ifdef REG_FILE_XCHG_EN
    read_sel = 5'b10010; chk("xchg_de", 16'hABCD);
    read_sel = 5'b10100; chk("xchg_hl", 16'h1234);
`else
    read_sel = 5'b10010; chk("xchg_de", 16'h1234);
    read_sel = 5'b10100; chk("xchg_hl", 16'hABCD);
`endif
    op(1, 5'd3, 16'h0077, 1, 1);
    sweep();
    op(0, 5'b10010, 16'h0000, 1, 1);
    sweep();
    op(0, 5'b10011, 16'h0000, 2, 0);
    sweep();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
